// File: rtl/icache_ctrl_if.sv
// CPU fetch port and instruction-memory line port of icache_ctrl.
// slave = cache side, master = CPU plus instruction memory side.
interface icache_ctrl_if #(
  parameter int ADDR_BITS = 10
);
  // CPU port: INSTRUCTION is valid in any cycle where BUSYWAIT=0.
  // Memory port: MEM_READ/MEM_ADDRESS hold steady until a posedge samples
  // MEM_BUSYWAIT=0; MEM_READDATA is taken on that same edge.
  logic [31:0]          PC;
  logic [31:0]          INSTRUCTION;
  logic                 BUSYWAIT;
  logic                 MEM_READ;
  logic [ADDR_BITS-5:0] MEM_ADDRESS;
  logic [127:0]         MEM_READDATA;
  logic                 MEM_BUSYWAIT;

  modport slave (
    input  PC, MEM_READDATA, MEM_BUSYWAIT,
    output INSTRUCTION, BUSYWAIT, MEM_READ, MEM_ADDRESS
  );

  modport master (
    output PC, MEM_READDATA, MEM_BUSYWAIT,
    input  INSTRUCTION, BUSYWAIT, MEM_READ, MEM_ADDRESS
  );
endinterface

// File: rtl/icache_ctrl.sv
// Direct-mapped read-only instruction cache, 4-word lines, single outstanding fill.
// Optional hit/miss counters are built when ICACHE_STATS_EN is defined.
module icache_ctrl #(
  parameter int ADDR_BITS  = 10,
  parameter int INDEX_BITS = 3
) (
  input  logic         CLK,
  input  logic         RESET,
  icache_ctrl_if.slave bus,
  output logic [1:0]   state_dbg
`ifdef ICACHE_STATS_EN
  ,
  output logic [15:0]  HIT_COUNT,
  output logic [15:0]  MISS_COUNT
`endif
);
  localparam int LINES     = 1 << INDEX_BITS;
  localparam int TAG_BITS  = ADDR_BITS - 4 - INDEX_BITS;
  localparam int LINE_BITS = ADDR_BITS - 4;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_FILL  = 2'd2;

  logic [1:0]            state_q;
  logic [LINE_BITS-1:0]  line_q;
  logic [LINES-1:0]      valid_q;
  logic [TAG_BITS-1:0]   tag_q  [LINES];
  logic [127:0]          data_q [LINES];

  logic [INDEX_BITS-1:0] pc_index;
  logic [TAG_BITS-1:0]   pc_tag;
  logic [INDEX_BITS-1:0] fill_index;
  logic                  hit;
  logic                  busy;
  logic                  fill_fire;
  logic [127:0]          pc_line;
  logic [31:0]           pc_word;
  logic                  pc_unused;

  assign pc_index   = bus.PC[3+INDEX_BITS:4];
  assign pc_tag     = bus.PC[ADDR_BITS-1:4+INDEX_BITS];
  assign pc_unused  = ^{bus.PC[31:ADDR_BITS], bus.PC[1:0]};
  assign fill_index = line_q[INDEX_BITS-1:0];
  assign pc_line    = data_q[pc_index];
  assign hit        = valid_q[pc_index] && (tag_q[pc_index] == pc_tag);
  assign busy       = (state_q != S_IDLE) || !hit;
  assign fill_fire  = (state_q == S_FETCH) && !bus.MEM_BUSYWAIT && !RESET;

  always_comb begin
    pc_word = pc_line[31:0];
    case (bus.PC[3:2])
      2'd1:    pc_word = pc_line[63:32];
      2'd2:    pc_word = pc_line[95:64];
      2'd3:    pc_word = pc_line[127:96];
      default: pc_word = pc_line[31:0];
    endcase
  end

  // Reset wins over every transition, which also drops a pending fill.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_IDLE;
      line_q  <= '0;
      valid_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!hit) begin
            state_q <= S_FETCH;
            line_q  <= {pc_tag, pc_index};
          end
        end
        S_FETCH: begin
          if (!bus.MEM_BUSYWAIT) begin
            state_q             <= S_FILL;
            valid_q[fill_index] <= 1'b1;
          end
        end
        S_FILL:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (fill_fire) begin
      data_q[fill_index] <= bus.MEM_READDATA;
      tag_q[fill_index]  <= line_q[LINE_BITS-1:INDEX_BITS];
    end
  end

  // Data array is not reset, so the word is forced to zero whenever stalled.
  assign bus.INSTRUCTION = busy ? 32'h0 : pc_word;
  assign bus.BUSYWAIT    = busy;
  assign bus.MEM_READ    = (state_q == S_FETCH) && !RESET;
  assign bus.MEM_ADDRESS = line_q;
  assign state_dbg       = state_q;

`ifdef ICACHE_STATS_EN
  logic [15:0] hit_cnt_q;
  logic [15:0] miss_cnt_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (state_q == S_IDLE) begin
      if (hit && (hit_cnt_q != 16'hFFFF)) hit_cnt_q <= hit_cnt_q + 16'd1;
      if (!hit && (miss_cnt_q != 16'hFFFF)) miss_cnt_q <= miss_cnt_q + 16'd1;
    end
  end

  assign HIT_COUNT  = hit_cnt_q;
  assign MISS_COUNT = miss_cnt_q;
`endif
endmodule

// File: doc/icache_ctrl.md
ICACHE_CTRL -- requirements
Module: icache_ctrl

Interface
REQ-001 Parameter ADDR_BITS, default 10: number of low PC bits decoded; PC[31:ADDR_BITS] SHALL be ignored.
REQ-002 Parameter INDEX_BITS, default 3: log2 of line count (8 lines); line = 4 words = 16 bytes.
REQ-003 CLK  input  1  clock; all state SHALL update on posedge CLK.
REQ-004 RESET  input  1  reset, synchronous, active-high.
REQ-005 PC  input  32  CPU fetch address; word offset PC[3:2], index PC[3+INDEX_BITS:4], tag PC[ADDR_BITS-1:4+INDEX_BITS]; PC[1:0] ignored.
REQ-006 INSTRUCTION  output  32  fetched word; valid when BUSYWAIT=0.
REQ-007 BUSYWAIT  output  1  stall to CPU; high while the current PC is not served.
REQ-008 MEM_READ  output  1  read request to instruction memory.
REQ-009 MEM_ADDRESS  output  ADDR_BITS-4  line address {tag,index} of the request.
REQ-010 MEM_READDATA  input  128  line from memory; word0 in bits [31:0].
REQ-011 MEM_BUSYWAIT  input  1  memory stall; data valid on the posedge where MEM_READ=1 and MEM_BUSYWAIT=0.

Function
REQ-012 Storage: per line one valid bit, one tag, 128-bit data; lookup SHALL be combinational.
REQ-013 States: IDLE, FETCH, FILL; encoding is free.
REQ-014 IDLE, hit (valid[index] and tag match): BUSYWAIT=0, INSTRUCTION=data[index] word PC[3:2], same cycle; stay IDLE.
REQ-015 IDLE, miss: BUSYWAIT=1 combinationally; next posedge -> FETCH, latch {tag,index} of PC.
REQ-016 FETCH: MEM_READ=1, MEM_ADDRESS=latched line, BUSYWAIT=1; stay while MEM_BUSYWAIT=1.
REQ-017 FETCH, posedge with MEM_BUSYWAIT=0: write MEM_READDATA, tag, valid=1 into latched index; -> FILL.
REQ-018 FILL: MEM_READ=0, BUSYWAIT=1; next posedge -> IDLE, where lookup re-evaluates (hit expected).
REQ-019 Miss latency: min 3 cycles of BUSYWAIT for zero-wait memory (IDLE-miss, FETCH, FILL).
REQ-020 PC changes during FETCH/FILL SHALL NOT alter the latched request; the fill completes and IDLE re-looks-up the new PC.
REQ-021 MEM_READ SHALL be 0 in IDLE and FILL; never two outstanding requests.
REQ-022 A fill SHALL replace the line unconditionally (no dirty state; read-only).
REQ-023 Outside IDLE INSTRUCTION value is don't-care to the CPU but SHALL be non-X after reset.

Reset
REQ-024 RESET=1 at posedge: all valid bits=0, state=IDLE, latched line=0; has priority over every transition.
REQ-025 During and after reset: MEM_READ=0, INSTRUCTION=0 while BUSYWAIT=1; BUSYWAIT reflects lookup (all miss) once RESET=0.
REQ-026 Reset in FETCH SHALL abort the request: MEM_READ=0 from the next cycle; the pending line SHALL NOT be written.

Configuration
REQ-027 Macro ICACHE_STATS_EN defined: add outputs HIT_COUNT (16) and MISS_COUNT (16), reset to 0, saturating at 16'hFFFF.
REQ-028 HIT_COUNT +1 per posedge in IDLE with hit and RESET=0; MISS_COUNT +1 per IDLE->FETCH transition.
REQ-029 Macro undefined: ports, counters and logic SHALL be absent; all other behaviour identical.

Verification
REQ-030 Reset, then PC=0, memory 2-cycle latency, line0 words 0x11,0x22,0x33,0x44 -> MEM_READ=1 MEM_ADDRESS=0, fill, then INSTRUCTION=0x11 BUSYWAIT=0.
REQ-031 After REQ-030, PC=4,8,12 consecutive cycles -> BUSYWAIT=0, INSTRUCTION 0x22,0x33,0x44, no MEM_READ.
REQ-032 PC=0x000 filled, then PC=0x080 (same index 0, tag 1) -> miss, MEM_ADDRESS=0x08; then PC=0x000 -> miss again (conflict eviction).
REQ-033 PC=0x010 miss, switch PC to 0x020 during FETCH -> line 0x01 filled first, then second miss MEM_ADDRESS=0x02.
REQ-034 RESET asserted during FETCH with MEM_BUSYWAIT=1 -> MEM_READ=0 next cycle; after release, PC of aborted line misses.
REQ-035 ICACHE_STATS_EN defined, run REQ-030/031 -> MISS_COUNT=1, HIT_COUNT=4; preload 16'hFFFF hits -> HIT_COUNT stays 16'hFFFF.
